// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencing logic.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_pipe_ctrl_if.sv
// Pipeline-side hazard/redirect inputs and fetch control outputs of fetch_pipe_ctrl.
interface fetch_pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ex_mem_pcsrc;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             imem_ready;
    logic             pc_we;
    logic             pc_sel;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output ex_mem_pcsrc, id_ex_memread, id_ex_rt, id_rs, id_rt, id_uses_rt, imem_ready,
        input  pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, state, stall_count, flush_count
    );

    modport slave (
        input  ex_mem_pcsrc, id_ex_memread, id_ex_rt, id_rs, id_rt, id_uses_rt, imem_ready,
        output pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush, state, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that needs the
// result of a load still in EX.
module hazard_detect
    import fetch_pkg::*;
(
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);

    // Loads into r0 never create a dependency since r0 is hardwired to zero.
    always_comb begin
        hazard = id_ex_memread && (id_ex_rt != REG_ZERO) &&
                 ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));
    end

endmodule

// File: rtl/fetch_pipe_ctrl.sv
// Fetch sequencing controller: boot hold, redirect flush window, load-use and
// imem-wait stalls, plus saturating stall/flush event counters.
module fetch_pipe_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned BOOT_CYCLES = 2,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pipe_ctrl_if.slave bus
);

    localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int unsigned FL_W   = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST    = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [FL_W-1:0]   FLUSH_RELOAD = FL_W'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);
    localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

    fetch_state_e      state_q, state_d;
    logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic hazard;
    logic stall_ev;
    logic flush_ev;
    logic pc_we, pc_sel, if_id_we, if_id_flush, id_ex_flush;

    hazard_detect u_hazard_detect (
        .id_ex_memread (bus.id_ex_memread),
        .id_ex_rt      (bus.id_ex_rt),
        .id_rs         (bus.id_rs),
        .id_rt         (bus.id_rt),
        .id_uses_rt    (bus.id_uses_rt),
        .hazard        (hazard)
    );

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        if_id_we    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            ST_RUN, ST_FLUSH: begin
                // Redirect outranks everything: the stalled/waiting work is wrong-path.
                if (bus.ex_mem_pcsrc) begin
                    pc_sel   = 1'b1;
                    pc_we    = 1'b1;
                    flush_ev = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_FLUSH) begin
                    pc_we       = bus.imem_ready;
                    id_ex_flush = 1'b0;
                    if (flush_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 1'b1;
                    end
                end else if (hazard) begin
                    if_id_we    = 1'b0;
                    if_id_flush = 1'b0;
                    stall_ev    = 1'b1;
                end else if (!bus.imem_ready) begin
                    id_ex_flush = 1'b0;
                    stall_ev    = 1'b1;
                end else begin
                    pc_we       = 1'b1;
                    if_id_flush = 1'b0;
                    id_ex_flush = 1'b0;
                end
            end
            default: begin
                state_d    = ST_BOOT;
                boot_cnt_d = '0;
            end
        endcase

        stall_count_d = (stall_ev && stall_count_q != CNT_MAX) ? stall_count_q + 1'b1 : stall_count_q;
        flush_count_d = (flush_ev && flush_count_q != CNT_MAX) ? flush_count_q + 1'b1 : flush_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            boot_cnt_q    <= '0;
            flush_cnt_q   <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.pc_sel      = pc_sel;
    assign bus.if_id_we    = if_id_we;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.state       = state_q;
    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Self-checking bench for fetch_pipe_ctrl against a cycle-count reference model.
module tb_fetch_pipe_ctrl;

    localparam int unsigned BOOT = 2;
    localparam int unsigned FD   = 2;
    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pcsrc, memread, uses_rt, ready;
    logic [4:0] ex_rt, rs, rt;

    int errors = 0;
    int checks = 0;

    // Reference model: cycles left in boot, cycles left in flush window, counters.
    int m_boot;
    int m_flush_left;
    int unsigned m_stall;
    int unsigned m_flush;

    fetch_pipe_ctrl_if #(.CNT_W(CW)) bus ();

    fetch_pipe_ctrl #(.BOOT_CYCLES(BOOT), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.ex_mem_pcsrc  = pcsrc;
    assign bus.id_ex_memread = memread;
    assign bus.id_ex_rt      = ex_rt;
    assign bus.id_rs         = rs;
    assign bus.id_rt         = rt;
    assign bus.id_uses_rt    = uses_rt;
    assign bus.imem_ready    = ready;

    logic [6:0]      obs_ctl;
    logic [2*CW-1:0] obs_cnt;
    assign obs_ctl = {bus.pc_we, bus.pc_sel, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush, bus.state};
    assign obs_cnt = {bus.stall_count, bus.flush_count};

    always #5 clk = ~clk;

    function automatic logic model_hazard();
        return memread && ex_rt != 5'd0 && (ex_rt == rs || (uses_rt && ex_rt == rt));
    endfunction

    function automatic logic [6:0] exp_ctl();
        logic [1:0] st;
        st = (m_boot > 0) ? 2'd0 : (m_flush_left > 0) ? 2'd2 : 2'd1;
        if (m_boot > 0)        return {5'b00111, st};
        if (pcsrc)             return {5'b11111, st};
        if (m_flush_left > 0)  return {ready, 4'b0110, st};
        if (model_hazard())    return {5'b00001, st};
        if (!ready)            return {5'b00110, st};
        return {5'b10100, st};
    endfunction

    function automatic logic [2*CW-1:0] exp_cnt();
        return {CW'(m_stall), CW'(m_flush)};
    endfunction

    task automatic advance();
        if (m_boot > 0) begin
            m_boot--;
        end else if (pcsrc) begin
            if (m_flush < CMAX) m_flush++;
            m_flush_left = FD - 1;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (model_hazard() || !ready) begin
            if (m_stall < CMAX) m_stall++;
        end
    endtask

    task automatic model_reset();
        m_boot = BOOT; m_flush_left = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic drive(input logic p, input logic mr, input logic [4:0] e, input logic [4:0] s,
                         input logic [4:0] t, input logic u, input logic r);
        pcsrc = p; memread = mr; ex_rt = e; rs = s; rt = t; uses_rt = u; ready = r;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    // Advances clock and model without comparing; used to reach a known point.
    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); advance(); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        idle();
    endtask

    task automatic test_reset();
        logic [2:0] we_seq;
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        settle(BOOT + 2);
        ready = 1'b0;
        settle(2);
        idle();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_async_state got %0d exp 0", bus.state); end
        checks++;
        if (obs_cnt !== '0) begin errors++; $display("FAIL reset_counters got %h exp 0", obs_cnt); end
        checks++;
        if (bus.pc_we !== 1'b0) begin errors++; $display("FAIL reset_pc_we got %b exp 0", bus.pc_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we_seq[2-i] = bus.pc_we;
            checks++;
            if (obs_ctl !== exp_ctl()) begin errors++; $display("FAIL reset_boot_ctl cyc %0d got %b exp %b", i, obs_ctl, exp_ctl()); end
            @(posedge clk); advance(); #1;
        end
        checks++;
        if (we_seq !== 3'b001) begin errors++; $display("FAIL reset_pc_we_seq got %b exp 001", we_seq); end
    endtask

    task automatic test_load_use();
        do_reset();
        settle(BOOT);
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (obs_ctl !== exp_ctl()) begin errors++; $display("FAIL load_use_ctl got %b exp %b", obs_ctl, exp_ctl()); end
        checks++;
        if ({bus.pc_we, bus.if_id_we, bus.id_ex_flush} !== 3'b001)
            begin errors++; $display("FAIL load_use_stall got %b exp 001", {bus.pc_we, bus.if_id_we, bus.id_ex_flush}); end
        @(posedge clk); advance(); #1;
        idle();
        @(negedge clk);
        checks++;
        if (bus.stall_count !== CW'(1)) begin errors++; $display("FAIL load_use_count got %0d exp 1", bus.stall_count); end
        checks++;
        if (obs_ctl !== exp_ctl()) begin errors++; $display("FAIL load_use_resume got %b exp %b", obs_ctl, exp_ctl()); end
        @(posedge clk); advance(); #1;
    endtask

    task automatic test_zero_reg();
        // {memread, ex_rt, rs, rt, uses_rt, stall expected}
        logic [17:0] rows [4];
        rows[0] = {1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
        rows[1] = {1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0};
        rows[2] = {1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b1};
        rows[3] = {1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0};
        do_reset();
        settle(BOOT);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, rows[i][17], rows[i][16:12], rows[i][11:7], rows[i][6:2], rows[i][1], 1'b1);
            @(negedge clk);
            checks++;
            if (bus.pc_we !== !rows[i][0]) begin errors++; $display("FAIL zero_reg_row%0d pc_we got %b exp %b", i, bus.pc_we, !rows[i][0]); end
            checks++;
            if (obs_ctl !== exp_ctl()) begin errors++; $display("FAIL zero_reg_row%0d ctl got %b exp %b", i, obs_ctl, exp_ctl()); end
            checks++;
            if (obs_cnt !== exp_cnt()) begin errors++; $display("FAIL zero_reg_row%0d cnt got %h exp %h", i, obs_cnt, exp_cnt()); end
            @(posedge clk); advance(); #1;
        end
        idle();
    endtask

    task automatic test_redirect();
        do_reset();
        settle(BOOT);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (obs_ctl !== 7'b11111_01) begin errors++; $display("FAIL redirect_ctl got %b exp 1111101", obs_ctl); end
        @(posedge clk); advance(); #1;
        idle();
        @(negedge clk);
        checks++;
        if ({bus.state, bus.if_id_flush} !== 3'b10_1) begin errors++; $display("FAIL redirect_flush_state got %b exp 101", {bus.state, bus.if_id_flush}); end
        checks++;
        if (obs_ctl !== exp_ctl()) begin errors++; $display("FAIL redirect_flush_ctl got %b exp %b", obs_ctl, exp_ctl()); end
        @(posedge clk); advance(); #1;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd1) begin errors++; $display("FAIL redirect_return got %0d exp 1", bus.state); end
        checks++;
        if (bus.flush_count !== CW'(1)) begin errors++; $display("FAIL redirect_count got %0d exp 1", bus.flush_count); end
        @(posedge clk); advance(); #1;
    endtask

    task automatic test_simultaneous();
        do_reset();
        settle(BOOT);
        drive(1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (obs_ctl !== 7'b11111_01) begin errors++; $display("FAIL simul_ctl got %b exp 1111101", obs_ctl); end
        @(posedge clk); advance(); #1;
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (obs_ctl !== exp_ctl()) begin errors++; $display("FAIL simul_reredirect got %b exp %b", obs_ctl, exp_ctl()); end
        @(posedge clk); advance(); #1;
        idle();
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd2) begin errors++; $display("FAIL simul_window_restart got %0d exp 2", bus.state); end
        checks++;
        if (obs_cnt !== {CW'(0), CW'(2)}) begin errors++; $display("FAIL simul_counts got %h exp stall 0 flush 2", obs_cnt); end
        @(posedge clk); advance(); #1;
        @(negedge clk);
        checks++;
        if (bus.state !== 2'd1) begin errors++; $display("FAIL simul_return got %0d exp 1", bus.state); end
        @(posedge clk); advance(); #1;
    endtask

    task automatic test_saturation();
        do_reset();
        settle(BOOT);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs_cnt !== exp_cnt()) begin errors++; $display("FAIL sat_cnt cyc %0d got %h exp %h", i, obs_cnt, exp_cnt()); end
            @(posedge clk); advance(); #1;
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus.stall_count !== CW'(15)) begin errors++; $display("FAIL sat_final got %0d exp 15", bus.stall_count); end
        @(posedge clk); advance(); #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            drive($urandom_range(0, 7) == 0, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (obs_ctl !== exp_ctl()) begin errors++; $display("FAIL rand_ctl cyc %0d got %b exp %b", i, obs_ctl, exp_ctl()); end
            checks++;
            if (obs_cnt !== exp_cnt()) begin errors++; $display("FAIL rand_cnt cyc %0d got %h exp %h", i, obs_cnt, exp_cnt()); end
            @(posedge clk); advance(); #1;
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        idle();
        model_reset();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_redirect();
        test_simultaneous();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
